// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the memory-mapped UART.
package uart_pkg;

    // Register offsets from BASE_ADDR
    localparam logic [31:0] OFF_TXD = 32'd0;
    localparam logic [31:0] OFF_RXD = 32'd4;
    localparam logic [31:0] OFF_CON = 32'd8;

    // UART_CON bit positions
    localparam int CON_TX_IE    = 0;
    localparam int CON_RX_IE    = 1;
    localparam int CON_TX_DONE  = 2;
    localparam int CON_RX_VALID = 3;
    localparam int CON_TX_BUSY  = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchroniser, mid-bit sampling FSM, one-cycle valid pulse.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int HALF  = CLKS_PER_BIT / 2;

    logic [1:0]       sync_q;
    logic             rx_s;
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic [7:0]       byte_q;
    logic             valid_q;

    assign rx_s    = sync_q[1];
    assign byte_o  = byte_q;
    assign valid_o = valid_q;

    // Synchronise the asynchronous serial input; idle level is high
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], rx_i};
    end

    // Receive FSM: confirm start at half-bit, then sample every full bit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) state_q <= RX_START;
                end
                RX_START: begin
                    if (cnt_q == CNT_W'(HALF - 1)) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        // a start that has gone high again by mid-bit was a glitch
                        state_q <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        if (bit_q == 3'd7) state_q <= RX_STOP;
                        else               bit_q   <= bit_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        // a low stop bit is a framing error: drop the byte
                        if (rx_s) begin
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TXD/RXD/CON register decode, TX FSM, RX core instance.
module uart_mmio
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Read_data,
    output logic        hit,
    output logic        uart_tx,
    input  logic        uart_rx,
    output logic        irq
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic sel_txd, sel_rxd, sel_con;
    logic wr_txd, wr_con, rd_rxd, rd_con;

    tx_state_e        tx_state_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [2:0]       tx_bit_q;
    logic [7:0]       txd_q;
    logic             tx_q;
    logic             tx_bit_end, tx_end, tx_busy;

    logic [7:0] rxd_q;
    logic       rx_valid_q;
    logic       tx_done_q;
    logic [1:0] ie_q;
    logic [7:0] rx_byte;
    logic       rx_vld;
    logic [4:0] con_rd;
    logic       unused_wdata;

    assign unused_wdata = ^Write_data[31:8];

    assign sel_txd = (Address == BASE_ADDR + OFF_TXD);
    assign sel_rxd = (Address == BASE_ADDR + OFF_RXD);
    assign sel_con = (Address == BASE_ADDR + OFF_CON);
    assign hit     = sel_txd | sel_rxd | sel_con;

    assign wr_txd = MemWrite & sel_txd;
    assign wr_con = MemWrite & sel_con;
    assign rd_rxd = MemRead  & sel_rxd;
    assign rd_con = MemRead  & sel_con;

    assign tx_bit_end = (tx_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign tx_end     = (tx_state_q == TX_STOP) && tx_bit_end;
    assign tx_busy    = (tx_state_q != TX_IDLE);
    assign uart_tx    = tx_q;

    assign irq = (ie_q[CON_RX_IE] & rx_valid_q) | (ie_q[CON_TX_IE] & tx_done_q);

    // Assemble the CON read image
    always_comb begin
        con_rd               = '0;
        con_rd[CON_TX_IE]    = ie_q[CON_TX_IE];
        con_rd[CON_RX_IE]    = ie_q[CON_RX_IE];
        con_rd[CON_TX_DONE]  = tx_done_q;
        con_rd[CON_RX_VALID] = rx_valid_q;
        con_rd[CON_TX_BUSY]  = tx_busy;
    end

    // Zero-latency load path, muxed by the CPU against DataMem using hit
    always_comb begin
        Read_data = '0;
        if (sel_txd)      Read_data = {24'd0, txd_q};
        else if (sel_rxd) Read_data = {24'd0, rxd_q};
        else if (sel_con) Read_data = {27'd0, con_rd};
    end

    // Transmit FSM; uart_tx is registered so the line never glitches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    // writes while busy fall through the other states untouched
                    if (wr_txd) begin
                        txd_q      <= Write_data[7:0];
                        tx_q       <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_q       <= txd_q[0];
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_bit_q <= tx_bit_q + 3'd1;
                            tx_q     <= txd_q[tx_bit_q + 3'd1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // Status/control registers; a set from the same edge beats a read-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie_q       <= '0;
            rxd_q      <= '0;
            rx_valid_q <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            if (wr_con) ie_q <= Write_data[1:0];
            if (rx_vld) begin
                rxd_q      <= rx_byte;
                rx_valid_q <= 1'b1;
            end else if (rd_rxd) begin
                rx_valid_q <= 1'b0;
            end
            if (tx_end)      tx_done_q <= 1'b1;
            else if (rd_con) tx_done_q <= 1'b0;
        end
    end

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i  (clk),
        .rst_ni (reset),
        .rx_i   (uart_rx),
        .byte_o (rx_byte),
        .valid_o(rx_vld)
    );

endmodule

// File: tb/tb_uart_mmio.sv
// Randomised self-checking bench for uart_mmio against a register-level model.
module tb_uart_mmio;

    localparam int          CPB   = 4;
    localparam logic [31:0] BASE  = 32'h4000_0018;
    localparam logic [31:0] A_TXD = BASE;
    localparam logic [31:0] A_RXD = BASE + 32'd4;
    localparam logic [31:0] A_CON = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address, Write_data, Read_data;
    logic        MemRead, MemWrite, hit, uart_tx, uart_rx, irq;

    int n_vec = 0;
    int n_err = 0;

    // model state
    logic [7:0] m_txd, m_rxd;
    logic       m_busy, m_rxv, m_txdone;
    logic [1:0] m_ie;

    // bytes decoded off uart_tx by an independent line monitor
    logic [7:0] txq[$];
    logic [7:0] mon_b;

    uart_mmio #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .Write_data(Write_data),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Read_data (Read_data),
        .hit       (hit),
        .uart_tx   (uart_tx),
        .uart_rx   (uart_rx),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] con_model();
        return {27'd0, m_busy, m_rxv, m_txdone, m_ie};
    endfunction

    function automatic logic irq_model();
        return (m_ie[1] & m_rxv) | (m_ie[0] & m_txdone);
    endfunction

    task automatic model_reset();
        m_txd = 8'h00; m_rxd = 8'h00; m_busy = 1'b0;
        m_rxv = 1'b0;  m_txdone = 1'b0; m_ie = 2'b00;
    endtask

    // Line monitor: decode each 8N1 frame at mid-bit
    initial forever begin
        @(negedge uart_tx);
        if (reset === 1'b1) begin
            repeat (CPB / 2) @(posedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(posedge clk);
                mon_b[k] = uart_tx;
            end
            repeat (CPB) @(posedge clk);
            if (uart_tx === 1'b1) txq.push_back(mon_b);
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        Address = a; Write_data = d; MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
        if (a == A_TXD && !m_busy) begin m_txd = d[7:0]; m_busy = 1'b1; end
        if (a == A_CON) m_ie = d[1:0];
    endtask

    task automatic rd(input logic [31:0] a, input string tag);
        logic [31:0] exp;
        @(negedge clk);
        Address = a; MemRead = 1'b1;
        #1;
        case (a)
            A_TXD:   exp = {24'd0, m_txd};
            A_RXD:   exp = {24'd0, m_rxd};
            A_CON:   exp = con_model();
            default: exp = 32'd0;
        endcase
        chk(tag, Read_data, exp);
        chk({tag, "_hit"}, hit, 1);
        @(negedge clk);
        MemRead = 1'b0;
        if (a == A_RXD) m_rxv = 1'b0;
        if (a == A_CON) m_txdone = 1'b0;
    endtask

    // Pull the next decoded byte with a bounded wait
    task automatic tx_pop(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 12 * CPB && txq.size() == 0; i++) @(negedge clk);
        if (txq.size() == 0) chk({tag, "_timeout"}, 0, 1);
        else                 chk(tag, txq.pop_front(), exp);
    endtask

    // Expect a whole frame, then let the stop bit finish and update the model
    task automatic tx_expect(input string tag, input logic [7:0] exp);
        tx_pop(tag, exp);
        repeat (3) @(negedge clk);
        m_busy = 1'b0; m_txdone = 1'b1;
    endtask

    // Check the line cycle-by-cycle; call right after the TXD write returns
    task automatic frame_chk(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++)
            for (int c = 0; c < CPB; c++) begin
                chk($sformatf("txbit%0d", k), uart_tx, fr[k]);
                @(negedge clk);
            end
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            uart_rx = fr[k];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    initial begin
        logic [7:0] b, b2;
        int gap;
        Address = '0; Write_data = '0; MemRead = 1'b0; MemWrite = 1'b0;
        uart_rx = 1'b1; reset = 1'b0;
        model_reset();

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", uart_tx, 1);
        chk("rst_irq", irq, 0);
        reset = 1'b1;
        rd(A_CON, "rst_con");
        rd(A_TXD, "rst_txd");
        rd(A_RXD, "rst_rxd");
        Address = BASE + 32'd12; #1;
        chk("miss_hit", hit, 0);
        chk("miss_data", Read_data, 0);
        Address = BASE - 32'd4; #1;
        chk("miss_hit_lo", hit, 0);

        // exact transmit waveform of 0xA5
        wr(A_TXD, 32'h1A5);
        frame_chk(8'hA5);
        tx_expect("tx_a5", 8'hA5);
        rd(A_CON, "con_done");
        rd(A_CON, "con_clr");

        // TXD write during a frame is dropped
        wr(A_TXD, 32'hA5);
        rd(A_CON, "con_busy");
        wr(A_TXD, 32'h33);
        rd(A_TXD, "txd_kept");
        tx_expect("tx_busywr", 8'hA5);
        rd(A_CON, "con_busywr");

        // write on the busy-fall edge is ignored, one cycle later accepted
        wr(A_TXD, 32'h3C);
        repeat (CPB * 10 - 1) @(negedge clk);
        Address = A_TXD; Write_data = 32'h81; MemWrite = 1'b1;
        @(negedge clk);
        Write_data = 32'h7E;
        @(negedge clk);
        MemWrite = 1'b0;
        tx_pop("b2b_first", 8'h3C);
        m_txd = 8'h7E; m_txdone = 1'b1;
        tx_expect("b2b_second", 8'h7E);
        rd(A_TXD, "b2b_txd");
        rd(A_CON, "b2b_con");

        // random transmit with tx interrupt
        wr(A_CON, 32'h1);
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            gap = $urandom_range(0, 5);
            wr(A_TXD, {24'd0, b});
            tx_expect("rtx", b);
            chk("rtx_irq", irq, irq_model());
            repeat (gap) @(negedge clk);
            rd(A_TXD, "rtx_txd");
            rd(A_CON, "rtx_con");
            chk("rtx_irq_clr", irq, irq_model());
        end

        // random receive with rx interrupt
        wr(A_CON, 32'h2);
        for (int i = 0; i < 4; i++) begin
            b = (i == 0) ? 8'h5C : 8'($urandom);
            send_rx(b, 1'b1);
            repeat (6) @(negedge clk);
            m_rxv = 1'b1; m_rxd = b;
            chk("rx_irq", irq, irq_model());
            rd(A_CON, "rx_con");
            rd(A_RXD, "rx_rxd");
            chk("rx_irq_clr", irq, irq_model());
            rd(A_CON, "rx_con_clr");
        end

        // overrun keeps the newest byte
        b = 8'($urandom); b2 = 8'($urandom);
        send_rx(b, 1'b1);
        send_rx(b2, 1'b1);
        repeat (6) @(negedge clk);
        m_rxv = 1'b1; m_rxd = b2;
        rd(A_CON, "ovr_con");
        rd(A_RXD, "ovr_rxd");

        // one-cycle glitch yields no byte
        @(negedge clk); uart_rx = 1'b0;
        @(negedge clk); uart_rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        chk("glitch_irq", irq, irq_model());
        rd(A_CON, "glitch_con");

        // framing error discards the byte
        send_rx(~m_rxd, 1'b0);
        repeat (12 * CPB) @(negedge clk);
        chk("frm_irq", irq, irq_model());
        rd(A_CON, "frm_con");
        rd(A_RXD, "frm_rxd");
        b = 8'($urandom);
        send_rx(b, 1'b1);
        repeat (6) @(negedge clk);
        m_rxv = 1'b1; m_rxd = b;
        rd(A_RXD, "frm_recover");

        // async reset in data bit 3
        wr(A_CON, 32'h3);
        wr(A_TXD, 32'hF0);
        repeat (4 * CPB + 1) @(negedge clk);
        chk("mid_bit3", uart_tx, 0);
        #1 reset = 1'b0;
        #1;
        chk("async_tx", uart_tx, 1);
        chk("async_irq", irq, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        rd(A_CON, "post_rst_con");
        rd(A_TXD, "post_rst_txd");
        repeat (12 * CPB) @(negedge clk);
        txq.delete();
        b = 8'($urandom);
        wr(A_TXD, {24'd0, b});
        frame_chk(b);
        tx_expect("post_rst_tx", b);
        rd(A_CON, "post_rst_done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped 8N1 UART peripheral that answers the pipeline CPU's MEM-stage load/store port. It sits beside the data memory on the same Address/Write_data/MemRead/MemWrite bus and decodes three word registers (UART_TXD, UART_RXD, UART_CON). It serialises bytes written by the CPU onto `uart_tx` and deserialises `uart_rx` into a byte the CPU polls or takes by interrupt.

## Interface
- CLKS_PER_BIT, 868, clock cycles per bit (100 MHz / 115200); minimum 4.
- BASE_ADDR, 32'h4000_0018, address of UART_TXD. UART_RXD is at BASE_ADDR+4; UART_CON is at BASE_ADDR+8.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- Address  in  32  byte address from the MEM stage.
- Write_data  in  32  store data.
- MemRead  in  1  load strobe.
- MemWrite  in  1  store strobe.
- Read_data  out  32  combinational load data; 0 when no register is hit.
- hit  out  1  combinational; Address matches one of the three registers. The CPU uses it to mux Read_data against DataMem.
- uart_tx  out  1  serial out; idles high.
- uart_rx  in  1  serial in; asynchronous to clk.
- irq  out  1  level interrupt.

## Operation
**Register reads**, zero-extended:
- TXD: last byte written.
- RXD: last received byte.
- CON[4:0]:
  - [4] tx_busy (RO)
  - [3] rx_valid (RO)
  - [2] tx_done (RO, sticky)
  - [1] rx_ie (RW)
  - [0] tx_ie (RW)

**Register writes** (MemWrite & hit, sampled at clk edge):
- TXD write while !tx_busy: latch Write_data[7:0], start a frame, set tx_busy.
- TXD write while tx_busy: ignored. No queueing, no flag.
- CON write: updates bits [1:0] only.
- RXD write: no effect.

**Read side effects** (MemRead & hit at clk edge):
- RXD read clears rx_valid.
- CON read clears tx_done.
- If the clear coincides with a set from the same edge (new byte / frame end), the set wins.

**Interrupt:**
- irq = (rx_ie & rx_valid) | (tx_ie & tx_done).

**TX FSM** (TX_IDLE → TX_START → TX_DATA → TX_STOP → TX_IDLE):
- Each state holds for CLKS_PER_BIT cycles.
- Data is sent LSB first; an 8-step bit index advances once per bit.
- Leaving TX_STOP clears tx_busy and sets tx_done.

**RX FSM** (RX_IDLE → RX_START → RX_DATA → RX_STOP → RX_IDLE):
- uart_rx passes through a 2-flop synchroniser before any logic.
- RX_IDLE exits on a synchronised low.
- RX_START waits CLKS_PER_BIT/2 cycles, then re-samples. If high, the start is treated as a glitch and the FSM returns to RX_IDLE.
- RX_DATA samples each bit at mid-bit, every CLKS_PER_BIT cycles, LSB first.
- RX_STOP samples the stop bit at mid-bit:
  - high: write the shift register to RXD and set rx_valid.
  - low (framing error): discard the byte, leave flags unchanged.
  - In both cases return to RX_IDLE.
- Overrun: a new valid byte overwrites RXD; rx_valid stays 1.

## Timing
**Reset values:**
- uart_tx=1, irq=0.
- All CON bits, TXD and RXD = 0.
- Both FSMs in IDLE; counters 0.
- Reset mid-frame aborts the frame immediately; uart_tx returns high asynchronously.

**TX timing:**
- The start bit drives uart_tx low on the first cycle after the TXD-write edge.
- A frame is exactly 10·CLKS_PER_BIT cycles.
- tx_busy falls on the same edge uart_tx completes the stop bit. A TXD write on that same edge is ignored; one cycle later it is accepted. Back-to-back frames therefore have a 1-cycle gap minimum.

**RX timing:**
- rx_valid rises 2 (synchroniser) + ~9.5·CLKS_PER_BIT cycles after the falling start edge.
- Tolerates ±4% baud mismatch.

**Read path:**
- Read_data/hit are purely combinational from Address and registers: zero-cycle latency, matching the DataMem read path.

## Structure
- Package uart_pkg:
  - register offsets (TXD=0, RXD=4, CON=8)
  - CON bit index constants
  - TX/RX state encodings (2-bit each)
- One natural sub-module: uart_rx_core (synchroniser + RX FSM, outputs byte + 1-cycle valid pulse).
- TX FSM and register decode stay in uart_mmio.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- **Reset:** deassert reset → uart_tx=1, Read_data at BASE+8 = 0, irq=0.
- **Transmit:** store 0x1A5 to BASE → uart_tx emits 0,1,0,1,0,0,1,0,1,1, 4 cycles each. CON reads 0x10 during the frame and 0x04 after. A second CON read returns 0x00.
- **Busy write:** store 0x33 to TXD during a frame → the frame still carries 0xA5; TXD reads 0xA5.
- **Receive + irq:**
  - Setup: set CON=0x02, drive a 0x5C frame on uart_rx.
  - rx_valid=1, irq=1, and BASE+4 reads 0x5C.
  - After that read, irq=0 and CON[3]=0.
- **Glitch/framing:**
  - A 1-cycle low pulse on uart_rx → no byte.
  - A frame with stop bit 0 → rx_valid stays 0 and RXD is unchanged.
- **Async reset mid-TX:** assert reset in bit 3 → uart_tx=1 in the same cycle. After release the FSM is idle, and a new TXD write starts a clean frame.
